// File: rtl/nibble_store_ctrl_pkg.sv
// Shared types and widths for the nibble store controller.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, PRESS, STORE, RELEASE} nsc_state_t;

endpackage

// File: rtl/nibble_store_ctrl_if.sv
// Button/switch inputs and store outputs of the nibble store controller.
interface nibble_store_ctrl_if #(parameter int W = nibble_pkg::NIBBLE_W);

  logic         btn;
  logic [W-1:0] sw;
  logic [W-1:0] D;
  logic         st;
  logic         busy;

  modport master (output btn, sw, input D, st, busy);
  modport slave  (input btn, sw, output D, st, busy);

endinterface

// File: rtl/nibble_store_ctrl_btn_sync.sv
// Two-flop synchroniser for the raw push-button; synchronous active-low reset to 0.
module btn_sync (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/nibble_store_ctrl.sv
// Debounced push-button capture of a W-bit switch value with a one-cycle store strobe.
// Optional accepted-press counter port entry_cnt when ENTRY_CNT_EN is defined.
module nibble_store_ctrl
  import nibble_pkg::*;
#(
  parameter int W         = NIBBLE_W,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               clr,
  nibble_store_ctrl_if.slave bus
`ifdef ENTRY_CNT_EN
  ,
  output logic [CNT_W-1:0]   entry_cnt
`endif
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic btn_s;

  btn_sync u_btn_sync (
    .clk      (clk),
    .clr      (clr),
    .async_in (bus.btn),
    .sync_out (btn_s)
  );

  nsc_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  d_q,     d_d;
  logic          st_q,    st_d;
  logic          busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end
      PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STORE;
          d_d     = bus.sw;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STORE: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so st/busy track state_q exactly.
    st_d   = (state_d == STORE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      st_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.D    = d_q;
  assign bus.st   = st_q;
  assign bus.busy = busy_q;

`ifdef ENTRY_CNT_EN
  logic [CNT_W-1:0] ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (st_q) ent_d = ent_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr) ent_q <= '0;
    else      ent_q <= ent_d;
  end

  assign entry_cnt = ent_q;
`endif

endmodule
